booth_mul_seq: RTL

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/booth_mul_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// Sequential signed 64x64 multiplier using radix-4 Booth recoding.
// One recoding step per clock; the 128-bit product is held in DONE until op_clear.
module booth_mul_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_start,
    input  logic         op_clear,
    input  logic [63:0]  multiplicand,
    input  logic [63:0]  multiplier,
    output logic         op_done,
    output logic [127:0] result,
    output logic [1:0]   state,
    output logic [7:0]   count
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXEC    = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [7:0] LAST_STEP = 8'd31;

    state_t        state_q, state_d;
    logic [63:0]   a_q, b_q;
    logic [129:0]  acc_q;
    logic          prev_q;
    logic [7:0]    count_q;
    logic [127:0]  result_q;

    logic [2:0]          window;
    logic signed [65:0]  a_ext, a_dbl, term, upper_sum;
    logic [129:0]        acc_step;
    logic                last_step;

    // Two guard bits above the 128-bit product keep +/-2A and the running sum exact,
    // including the -2^63 * -2^63 case.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        term      = '0;
        window    = {b_q[1:0], prev_q};
        a_ext     = {{2{a_q[63]}}, a_q};
        a_dbl     = {a_q[63], a_q, 1'b0};
        case (window)
            3'b001, 3'b010: term = a_ext;
            3'b011:         term = a_dbl;
            3'b100:         term = -a_dbl;
            3'b101, 3'b110: term = -a_ext;
            default:        term = '0;
        endcase
        upper_sum = $signed(acc_q[129:64]) + term;
        acc_step  = $signed({upper_sum, acc_q[63:0]}) >>> 2;
        last_step = (count_q == LAST_STEP);
    end

    always_comb begin
        state_d = state_q;
        if (op_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (op_start) state_d = EXEC;
                EXEC:    if (last_step) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset || op_clear || state_q == ILLEGAL) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            prev_q   <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        a_q     <= multiplicand;
                        b_q     <= multiplier;
                        acc_q   <= '0;
                        prev_q  <= 1'b0;
                        count_q <= '0;
                    end
                end
                EXEC: begin
                    acc_q   <= acc_step;
                    prev_q  <= b_q[1];
                    b_q     <= $signed(b_q) >>> 2;
                    count_q <= count_q + 8'd1;
                    if (last_step) result_q <= acc_step[127:0];
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign op_done = (state_q == DONE);
    assign result  = result_q;
    assign count   = count_q;

endmodule
